down_counter_timer: RTL and testbench

Loadable N-bit down counter with terminal-count detection, one-shot and auto-reload modes, built as the counterpart to the team's free-running up counter. It counts down from a loaded value while enabled and flags expiry with a one-cycle pulse. It either stops at zero or reloads and repeats. Intended as a programmable interval/timeout source for FSMs elsewhere in the design.

---
 rtl/down_counter_timer_if.sv | 25 ++
 rtl/down_counter_timer.sv | 114 +++++++++++
 tb/tb_down_counter_timer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer.
// The master (an FSM or the bench) drives the controls.
// The slave (the timer) returns the count and the status flags.
interface down_counter_timer_if #(
  parameter int N = 4
);
  logic         en;
  logic         load;
  logic [N-1:0] load_val;
  logic         mode;
  logic [N-1:0] Q;
  logic         tc;
  logic         busy;
  logic         done;

  modport master (
    output en, load, load_val, mode,
    input  Q, tc, busy, done
  );

  modport slave (
    input  en, load, load_val, mode,
    output Q, tc, busy, done
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable N-bit down counter with a registered terminal-count pulse.
// It has a one-shot mode and an auto-reload mode.
// Edge priority: load > expiry > decrement > hold.
// The count never wraps from zero; DONE is left only by load or reset.
module down_counter_timer #(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  down_counter_timer_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] r_q;
  logic [N-1:0] r_reload;
  logic         r_mode;
  logic [1:0]   r_state;
  logic         r_tc;
  logic         r_busy;
  logic         r_done;

  logic [N-1:0] w_q;
  logic [N-1:0] w_reload;
  logic         w_mode;
  logic [1:0]   w_state;
  logic         w_tc;

  // Next-state selection: load first, then expiry, then decrement, otherwise hold.
  always_comb begin
    w_q      = r_q;
    w_reload = r_reload;
    w_mode   = r_mode;
    w_state  = r_state;
    w_tc     = 1'b0;
    if (bus.load) begin
      w_q      = bus.load_val;
      w_reload = bus.load_val;
      w_mode   = bus.mode;
      if (bus.load_val != CNT_ZERO) begin
        w_state = ST_RUN;
      end else begin
        w_state = ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.en) begin
            if (r_q == CNT_ONE) begin
              w_tc = 1'b1;
              if (r_mode) begin
                w_q = r_reload;
              end else begin
                w_q     = CNT_ZERO;
                w_state = ST_DONE;
              end
            end else if (r_q > CNT_ONE) begin
              w_q = r_q - CNT_ONE;
            end else begin
              // A zero count in RUN cannot be reached through a load.
              // Holding here keeps the count from wrapping.
              w_q = r_q;
            end
          end else begin
            w_q = r_q;
          end
        end
        ST_IDLE: begin
          w_state = ST_IDLE;
        end
        ST_DONE: begin
          w_state = ST_DONE;
        end
        default: begin
          // Recover from an unused encoding to a safe stopped state.
          w_q     = CNT_ZERO;
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; busy/done are registered copies of the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q      <= CNT_ZERO;
      r_reload <= CNT_ZERO;
      r_mode   <= 1'b0;
      r_state  <= ST_IDLE;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_q      <= w_q;
      r_reload <= w_reload;
      r_mode   <= w_mode;
      r_state  <= w_state;
      r_tc     <= w_tc;
      r_busy   <= (w_state == ST_RUN);
      r_done   <= (w_state == ST_DONE);
    end
  end

  assign bus.Q    = r_q;
  assign bus.tc   = r_tc;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer (N=4).
// Directed scenarios are followed by a randomized phase.
// All outputs are checked against a behavioural timer model.
module tb_down_counter_timer;

  localparam int N = 4;

  logic clk;
  logic reset_n;

  down_counter_timer_if #(.N(N)) bus ();

  down_counter_timer #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: remaining count, remembered period, and a status of
  // counting / expired / stopped.
  int m_count;
  int m_period;
  bit m_auto;
  bit m_counting;
  bit m_expired;
  bit m_pulse;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count    = 0;
    m_period   = 0;
    m_auto     = 1'b0;
    m_counting = 1'b0;
    m_expired  = 1'b0;
    m_pulse    = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input int val, input bit md);
    m_pulse = 1'b0;
    if (ld) begin
      m_count    = val;
      m_period   = val;
      m_auto     = md;
      m_counting = (val != 0);
      m_expired  = 1'b0;
    end else if (m_counting && en) begin
      if (m_count == 1) begin
        m_pulse = 1'b1;
        if (m_auto) begin
          m_count = m_period;
        end else begin
          m_count    = 0;
          m_counting = 1'b0;
          m_expired  = 1'b1;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_q"},    32'(bus.Q),    32'(m_count));
    chk({tag, "_tc"},   32'(bus.tc),   32'(m_pulse));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(m_counting));
    chk({tag, "_done"}, 32'(bus.done), 32'(m_expired));
  endtask

  // Drive inputs (called just after a falling edge), clock one rising edge, check.
  task automatic step(input string tag, input bit en, input bit ld, input int val, input bit md);
    bus.en       = en;
    bus.load     = ld;
    bus.load_val = val[N-1:0];
    bus.mode     = md;
    @(posedge clk);
    model_edge(en, ld, val, md);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    int tc_seen;
    int en_edges;
    reset_n      = 1'b0;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.mode     = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Enable without load: nothing moves.
    tc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step("idle_en", 1'b1, 1'b0, 0, 1'b0);
      tc_seen += int'(bus.tc);
    end
    chk("idle_tc_count", 32'(tc_seen), 32'd0);

    // One-shot from 5: the count goes 5,4,3,2,1,0 and then stays at 0.
    step("os_load", 1'b1, 1'b1, 5, 1'b0);
    chk("os_load_q", 32'(bus.Q), 32'd5);
    for (int i = 4; i >= 0; i--) begin
      step("os_run", 1'b1, 1'b0, 0, 1'b0);
      chk("os_seq_q", 32'(bus.Q), 32'(i));
    end
    chk("os_tc_at_zero", 32'(bus.tc), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step("os_hold", 1'b1, 1'b0, 0, 1'b1);
      chk("os_nowrap_q", 32'(bus.Q), 32'd0);
    end

    // Auto-reload with period 3.
    step("ar_load", 1'b1, 1'b1, 3, 1'b1);
    tc_seen = 0;
    for (int i = 1; i <= 9; i++) begin
      step("ar_run", 1'b1, 1'b0, 0, 1'b0);
      chk("ar_seq_q", 32'(bus.Q), 32'(3 - (i % 3)));
      tc_seen += int'(bus.tc);
    end
    chk("ar_tc_count", 32'(tc_seen), 32'd3);

    // Load 4 with en toggling: tc comes after the fourth enabled edge.
    step("tog_load", 1'b0, 1'b1, 4, 1'b0);
    en_edges = 0;
    for (int i = 0; i < 8; i++) begin
      step("tog_run", (i % 2) == 0, 1'b0, 0, 1'b0);
      if ((i % 2) == 0) en_edges++;
      if (bus.tc) chk("tog_tc_edges", 32'(en_edges), 32'd4);
    end
    chk("tog_done", 32'(bus.done), 32'd1);

    // A load that coincides with an expiry wins.
    step("pre_load", 1'b1, 1'b1, 2, 1'b0);
    step("pre_run",  1'b1, 1'b0, 0, 1'b0);
    step("pre_win",  1'b1, 1'b1, 7, 1'b0);
    chk("pre_win_tc", 32'(bus.tc), 32'd0);
    chk("pre_win_q",  32'(bus.Q),  32'd7);
    step("zero_load", 1'b1, 1'b1, 0, 1'b1);
    step("zero_hold", 1'b1, 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of a count.
    step("rst_load", 1'b1, 1'b1, 9, 1'b0);
    step("rst_run",  1'b1, 1'b0, 0, 1'b0);
    step("rst_run",  1'b1, 1'b0, 0, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    #3;
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      step("rst_after", 1'b1, 1'b0, 0, 1'b0);
    end

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      step("rnd", $urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0,
           int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
